// File: rtl/segment_pkg.sv
// rtl/segment_pkg.sv - shared constants and types for the seven-segment readback decoder
// Purpose: segment pattern tables for units/tens digits, blank pattern and the
//   decoder state enum. Bit order is {bit8, DP, g, f, e, d, c, b, a}.
package segment_pkg;

  // Units digit patterns: DP clear, bit8 clear.
  localparam logic [8:0] SEG_UNITS [0:9] = '{
    9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066,
    9'h06d, 9'h07d, 9'h007, 9'h07f, 9'h06f
  };

  // Tens digit patterns: same segments with DP set.
  localparam logic [8:0] SEG_TENS [0:9] = '{
    9'h0bf, 9'h086, 9'h0db, 9'h0cf, 9'h0e6,
    9'h0ed, 9'h0fd, 9'h087, 9'h0ff, 9'h0ef
  };

  localparam logic [8:0] SEG_BLANK = 9'h000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2,
    BAD    = 2'd3
  } seg_state_e;

endpackage

// File: rtl/seg_lookup.sv
// rtl/seg_lookup.sv - combinational seven-segment pattern to BCD lookup
// Purpose: maps one 9-bit segment pattern to a digit 0..9 and a legal flag.
// Parameters: DP_EXPECTED - required value of the DP bit (0 units, 1 tens).
// Ports:
//   pattern in  9  segment pattern (already polarity-corrected)
//   legal   out 1  pattern matches one of the ten digit patterns exactly
//   digit   out 4  decoded digit, 0 when not legal
module seg_lookup
  import segment_pkg::*;
#(
  parameter bit DP_EXPECTED = 1'b0
) (
  input  logic [8:0] pattern,
  output logic       legal,
  output logic [3:0] digit
);

  logic [8:0] ref_pat;

  // Exact match against the table also rejects a wrong DP bit or bit8 set.
  always_comb begin
    legal   = 1'b0;
    digit   = 4'd0;
    ref_pat = 9'h000;
    for (int i = 0; i < 10; i++) begin
      ref_pat = DP_EXPECTED ? SEG_TENS[i] : SEG_UNITS[i];
      if (pattern == ref_pat) begin
        legal = 1'b1;
        digit = i[3:0];
      end
    end
  end

endmodule

// File: rtl/segment_decoder.sv
// rtl/segment_decoder.sv - two-digit seven-segment readback decoder with stability filter
// Purpose: samples the units/tens LED patterns, requires STABLE_CYCLES identical
//   samples before committing, recovers BCD digits and flags illegal patterns.
// Config: define SEG_ACTIVE_LOW_EN for common-anode displays (inputs inverted
//   in the input stage; blank is then raw 9'h1FF on both).
// Ports:
//   clk         in  1  main clock
//   rst         in  1  synchronous active-high reset
//   led_1       in  9  units pattern (DP=0, bit8=0)
//   led_2       in  9  tens pattern (DP=1, bit8=0)
//   err_clr     in  1  clears sticky err on the next edge
//   digit_units out 4  last committed units digit
//   digit_tens  out 4  last committed tens digit
//   valid       out 1  digits reflect a stable, legal, current pattern
//   update      out 1  one-cycle pulse on each legal commit
//   err         out 1  sticky illegal-pattern flag
module segment_decoder
  import segment_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] led_1,
  input  logic [8:0] led_2,
  input  logic       err_clr,
  output logic [3:0] digit_units,
  output logic [3:0] digit_tens,
  output logic       valid,
  output logic       update,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // samp holds {tens, units} as sampled; prev is samp one cycle later.
  logic [17:0]      samp_q, samp_d;
  logic [17:0]      prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  seg_state_e       state_q, state_d;
  logic [3:0]       units_q, units_d;
  logic [3:0]       tens_q, tens_d;
  logic             valid_q, valid_d;
  logic             update_q, update_d;
  logic             err_q, err_d;

  logic             u_legal, t_legal;
  logic [3:0]       u_digit, t_digit;
  logic             changed, blank;

`ifdef SEG_ACTIVE_LOW_EN
  assign samp_d = ~{led_2, led_1};
`else
  assign samp_d = {led_2, led_1};
`endif
  assign prev_d = samp_q;

  seg_lookup #(.DP_EXPECTED(1'b0)) u_lookup_units (
    .pattern (samp_q[8:0]),
    .legal   (u_legal),
    .digit   (u_digit)
  );

  seg_lookup #(.DP_EXPECTED(1'b1)) u_lookup_tens (
    .pattern (samp_q[17:9]),
    .legal   (t_legal),
    .digit   (t_digit)
  );

  assign changed = (samp_q != prev_q);
  assign blank   = (samp_q[8:0] == SEG_BLANK) && (samp_q[17:9] == SEG_BLANK);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    units_d  = units_q;
    tens_d   = tens_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    err_d    = err_q & ~err_clr;

    // Any sample change restarts settling regardless of state.
    if (changed) begin
      cnt_d   = '0;
      valid_d = 1'b0;
      state_d = SETTLE;
    end else begin
      case (state_q)
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            if (blank) begin
              valid_d = 1'b0;
              state_d = IDLE;
            end else if (u_legal && t_legal) begin
              units_d  = u_digit;
              tens_d   = t_digit;
              update_d = 1'b1;
              valid_d  = 1'b1;
              state_d  = LOCKED;
            end else begin
              // Set has priority over a same-cycle err_clr.
              err_d   = 1'b1;
              valid_d = 1'b0;
              state_d = BAD;
            end
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q   <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      units_q  <= 4'd0;
      tens_q   <= 4'd0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      samp_q   <= samp_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      units_q  <= units_d;
      tens_q   <= tens_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

  assign digit_units = units_q;
  assign digit_tens  = tens_q;
  assign valid       = valid_q;
  assign update      = update_q;
  assign err         = err_q;

endmodule

// File: tb/tb_segment_decoder.sv
// tb/tb_segment_decoder.sv - scoreboard bench for segment_decoder
module tb_segment_decoder;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] led_1;
  logic [8:0] led_2;
  logic       err_clr = 1'b0;
  logic [3:0] digit_units, digit_tens;
  logic       valid, update, err;

  segment_decoder #(.STABLE_CYCLES(SC), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .led_1       (led_1),
    .led_2       (led_2),
    .err_clr     (err_clr),
    .digit_units (digit_units),
    .digit_tens  (digit_tens),
    .valid       (valid),
    .update      (update),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Reference pattern tables, written out independently of the design package.
  logic [8:0] tu [0:9] = '{9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066,
                           9'h06d, 9'h07d, 9'h007, 9'h07f, 9'h06f};

  int checks   = 0;
  int failures = 0;

  // Expected {tens, units} of every legal commit, in order.
  logic [7:0] exp_q [$];

  // Behavioural model state.
  bit         m_valid = 0;
  bit         m_err   = 0;
  int         m_u     = 0;
  int         m_t     = 0;
  logic [8:0] last_u  = 9'h000;
  logic [8:0] last_t  = 9'h000;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns digit 0..9, or -1 when the pattern is not a legal digit for that position.
  function automatic int decode(input logic [8:0] p, input bit tens);
    logic [8:0] want;
    for (int i = 0; i < 10; i++) begin
      want = tu[i];
      if (tens) want[7] = 1'b1;
      if (p == want) return i;
    end
    return -1;
  endfunction

  task automatic set_pins(input logic [8:0] u, input logic [8:0] t);
`ifdef SEG_ACTIVE_LOW_EN
    led_1 = ~u;
    led_2 = ~t;
`else
    led_1 = u;
    led_2 = t;
`endif
  endtask

  // Model effect of a pattern that will be held long enough to commit.
  task automatic model_commit(input logic [8:0] u, input logic [8:0] t);
    int du, dt;
    du = decode(u, 1'b0);
    dt = decode(t, 1'b1);
    if (u == 9'h000 && t == 9'h000) begin
      m_valid = 0;
    end else if (du >= 0 && dt >= 0) begin
      m_valid = 1;
      m_u = du;
      m_t = dt;
      exp_q.push_back({4'(dt), 4'(du)});
    end else begin
      m_valid = 0;
      m_err   = 1;
    end
  endtask

  // Drive a new pattern; commit=1 means the caller will hold it past settling.
  task automatic drive(input logic [8:0] u, input logic [8:0] t, input bit commit);
    set_pins(u, t);
    if (u != last_u || t != last_t) begin
      m_valid = 0;
      if (commit) model_commit(u, t);
    end
    last_u = u;
    last_t = t;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_valid"}, valid, m_valid);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_units"}, digit_units, m_u);
    chk({tag, "_tens"}, digit_tens, m_t);
  endtask

  // Monitor: every update pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (update) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL update_unexpected: got pulse with digits %0d%0d expected none (t=%0t)",
                 digit_tens, digit_units, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("upd_units", digit_units, e[3:0]);
        chk("upd_tens", digit_tens, e[7:4]);
      end
    end
  end

  initial begin
    logic [8:0] ru, rt;
    int         sel, hold;
    bit         long_seg;

    set_pins(9'h000, 9'h000);
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_update", update, 0);
    check_state("rst");

    // Basic commit and exact update latency.
    drive(9'h05b, 9'h0cf, 1'b1);
    for (int k = 0; k <= 6; k++) begin
      tick(1);
      chk("lat_update", update, (k == 5) ? 1 : 0);
    end
    check_state("lock32");

    // Short glitch on units, then restore.
    drive(9'h006, 9'h0cf, 1'b0);
    tick(3);
    chk("glitch_valid", valid, 0);
    drive(9'h05b, 9'h0cf, 1'b1);
    tick(5);
    chk("recommit_early", update, 0);
    tick(1);
    chk("recommit_update", update, 1);
    tick(1);
    check_state("relock32");

    // Missing DP on tens is illegal; digits hold; err_clr clears while held.
    drive(9'h05b, 9'h04f, 1'b1);
    tick(10);
    check_state("illegal");
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_err = 0;
    chk("errclr", err, 0);
    tick(5);
    chk("errclr_hold", err, 0);

    // Blank on both: no update, no err.
    drive(9'h000, 9'h000, 1'b1);
    tick(10);
    check_state("blank");

    // Reset in the middle of settling aborts the commit.
    drive(9'h06d, 9'h0ed, 1'b0);
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_valid = 0; m_err = 0; m_u = 0; m_t = 0;
    chk("midrst_update", update, 0);
    check_state("midrst");
    model_commit(9'h06d, 9'h0ed);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("midrst_settle", update, 0);
    end
    tick(1);
    chk("midrst_commit", update, 1);
    tick(1);
    check_state("lock55");

    // Illegal commit on the same edge as err_clr: set wins.
    drive(9'h05b, 9'h05b, 1'b1);
    tick(5);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("set_wins", err, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_err = 0;
    chk("clr_after", err, 0);

    // All 100 legal pairs.
    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        ru = tu[u];
        rt = tu[t] | 9'h080;
        drive(ru, rt, 1'b1);
        tick(SC + 2);
        check_state("sweep");
      end
    end

    // Random segments: mixes of legal, blank, illegal, glitches and long holds.
    for (int n = 0; n < 200; n++) begin
      do begin
        sel = $urandom_range(0, 9);
        ru  = tu[$urandom_range(0, 9)];
        rt  = tu[$urandom_range(0, 9)] | 9'h080;
        if (sel == 7) begin
          ru = 9'h000;
          rt = 9'h000;
        end else if (sel == 8) begin
          ru = 9'($urandom);
          rt = 9'($urandom);
        end else if (sel == 9) begin
          if ($urandom_range(0, 1) == 1) ru = ru ^ 9'h080;
          else rt = rt | 9'h100;
        end
      end while (ru == last_u && rt == last_t);
      long_seg = ($urandom_range(0, 1) == 1);
      hold = long_seg ? $urandom_range(SC + 2, SC + 8) : $urandom_range(1, SC);
      drive(ru, rt, long_seg);
      tick(hold);
      if (long_seg) check_state("rand");
    end

    tick(SC + 4);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/segment_decoder.md
Name: segment_decoder

Overview:
- Receive side of the two-digit seven-segment display interface: samples the 9-bit units/tens segment patterns and recovers the BCD digits.
- Filters transient patterns with a stability counter and flags illegal patterns.
- Used for display readback and self-check: placed alongside the stopwatch to verify what is actually driven to the LEDs.
- Runs in the main clock domain; inputs are sampled asynchronously to their source.

Parameters:
STABLE_CYCLES, 16, consecutive identical samples required before a pattern is committed (legal range 2..65535)
CNT_W, 16, width of the stability counter (must hold STABLE_CYCLES-1)

Ports:
clk  in  1  main clock
rst  in  1  reset; synchronous, active-high
led_1  in  9  units pattern; bit7 (DP) must be 0, bit8 must be 0
led_2  in  9  tens pattern; bit7 (DP) must be 1, bit8 must be 0
err_clr  in  1  clears sticky err
digit_units  out  4  last committed units digit, 0..9
digit_tens  out  4  last committed tens digit, 0..9
valid  out  1  high while the digit outputs reflect a stable, legal, current pattern
update  out  1  one-cycle pulse on each legal commit
err  out  1  sticky illegal-pattern flag

Behaviour:
- Reset (rst high at clk edge): digits=0, valid=0, update=0, err=0, state=IDLE, cnt=0, sample registers=0.
- Input stage: s <= {led_2,led_1} every cycle; s_d <= s.
- Change detect: s != s_d -> cnt<=0, valid<=0, state<=SETTLE. This applies in every state and overrides all other transitions.
- Decode, units: 9'h3f,06,5b,4f,66,6d,7d,07,7f,6f -> 0..9.
- Decode, tens: same values with bit7 set (9'hBF,86,DB,CF,E6,ED,FD,87,FF,EF) -> 0..9.
- Any other value, including a wrong DP bit or bit8 set, is illegal.
- Blank: both patterns 9'h000 is legal-blank. On commit: valid=0, update=0, no err, digits held, state IDLE.
- States:
  - IDLE: waits for a change.
  - SETTLE: if s == s_d, cnt increments. At cnt == STABLE_CYCLES-1, commit:
    - Legal: load digits, update=1 for one cycle, valid=1, state LOCKED.
    - Illegal: err<=1, valid=0, digits held, state BAD.
    - Blank: go to IDLE.
  - LOCKED / BAD: hold until the next change.
- Latency: inputs changed before edge 0 and held -> commit registered at edge STABLE_CYCLES+1; update visible the cycle after that edge.
- A glitch shorter than STABLE_CYCLES restarts settling. An identical pattern re-committed after a glitch still pulses update.
- err is sticky: err_clr clears it next edge. A simultaneous illegal commit and err_clr leaves err=1 (set wins).
- cnt saturates, never wraps. rst mid-SETTLE aborts without a commit.

Optional Feature:
- SEG_ACTIVE_LOW_EN defined: both 9-bit inputs are inverted in the input stage before all comparison and decode (common-anode displays). Blank then corresponds to raw 9'h1FF on both.
- Undefined: inputs are used as-is (active-high segments).

Decomposition:
- segment_pkg:
  - SEG_UNITS[0:9] and SEG_TENS[0:9] pattern constants.
  - SEG_BLANK constant.
  - state enum {IDLE, SETTLE, LOCKED, BAD}.
- Sub-module seg_lookup:
  - Combinational pattern -> {legal, digit[3:0]}.
  - Parameter DP_EXPECTED.
  - Instanced twice: units with DP_EXPECTED=0, tens with DP_EXPECTED=1.

Test Plan:
- STABLE_CYCLES=4; after reset apply led_1=9'h5b, led_2=9'hCF -> update pulse in the cycle after edge 5; digit_units=2, digit_tens=3, valid=1, err=0.
- From locked 32: drive led_1=9'h06 for 3 cycles, then back to 9'h5b -> valid drops in the cycle after edge 2, no update during the glitch; recommit to 32 with update pulse 5 edges after restore.
- Apply led_2=9'h4f (DP missing) held 10 cycles -> err=1, valid=0, digits hold previous value; pulse err_clr while the pattern is still held -> err=0 next cycle; no re-set without a new change.
- Apply both inputs 9'h000 -> valid=0, err=0, update never pulses.
- Assert rst for 1 cycle at cnt=2 during SETTLE -> all outputs 0 next cycle; no update until the full settle completes after release.
- Illegal commit coinciding with err_clr -> err remains 1. Sweep all 100 legal digit pairs -> exact BCD each time.
